// File: rtl/instr_encoder_loader.sv
// ---------------------------------------------------------------------------
// instr_encoder_loader
//
// Purpose:
//   Encode-side counterpart of the pipeline's opcode decoder. The block takes
//   symbolic instruction fields over a valid/ready handshake, packs them into
//   32-bit RV32I words and writes those words one after another into
//   instruction memory. It bootstraps program memory while the core is still
//   held in stall.
//
//   Supported formats match the decoder: R, I, S, B, J, U (LUI), LW and JALR.
//   A bundle whose immediate cannot be represented in its format is rejected.
//   A rejection raises a one-cycle err pulse, performs no write and leaves the
//   address and word count unchanged.
//
// Parameters:
//   ADDR_W  width of the instruction-memory byte address
//   DEPTH   number of words that fill one load session
//
// Ports:
//   clk        clock; all logic on the rising edge
//   rst        synchronous, active-low reset
//   start      one-cycle pulse that opens, or restarts, a load session
//   in_valid   field bundle valid
//   in_ready   block accepts a bundle this cycle (decoded from state only)
//   fmt        0=R 1=I 2=S 3=B 4=J 5=U 6=LW 7=JALR
//   rd/rs1/rs2 register indices
//   funct3     funct3 field
//   funct7     funct7 field (R only)
//   imm        signed byte immediate (full 32-bit value for U)
//   mem_we     instruction-memory write strobe
//   mem_addr   byte address of the write
//   mem_wdata  encoded instruction
//   err        one-cycle pulse: the bundle was rejected
//   err_count  saturating count of rejected bundles
//   words      words written in the current session
//   done       session full (words == DEPTH)
// ---------------------------------------------------------------------------
module instr_encoder_loader #(
    parameter int ADDR_W = 10,
    parameter int DEPTH  = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        fmt,
    input  logic [4:0]        rd,
    input  logic [4:0]        rs1,
    input  logic [4:0]        rs2,
    input  logic [2:0]        funct3,
    input  logic [6:0]        funct7,
    input  logic [31:0]       imm,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              err,
    output logic [7:0]        err_count,
    output logic [ADDR_W-1:0] words,
    output logic              done
);

    // Format codes carried on the fmt input
    localparam logic [2:0] FMT_R    = 3'd0;
    localparam logic [2:0] FMT_I    = 3'd1;
    localparam logic [2:0] FMT_S    = 3'd2;
    localparam logic [2:0] FMT_B    = 3'd3;
    localparam logic [2:0] FMT_J    = 3'd4;
    localparam logic [2:0] FMT_U    = 3'd5;
    localparam logic [2:0] FMT_LW   = 3'd6;
    localparam logic [2:0] FMT_JALR = 3'd7;

    // Major opcodes, identical to the ones the decoder matches on
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_S    = 7'b0100011;
    localparam logic [6:0] OP_B    = 7'b1100011;
    localparam logic [6:0] OP_J    = 7'b1101111;
    localparam logic [6:0] OP_U    = 7'b0110111;
    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_JALR = 7'b1100111;

    // Signed immediate limits for each encodable range
    localparam logic signed [31:0] IMM12_MIN = -32'sd2048;
    localparam logic signed [31:0] IMM12_MAX =  32'sd2047;
    localparam logic signed [31:0] IMM13_MIN = -32'sd4096;
    localparam logic signed [31:0] IMM13_MAX =  32'sd4094;
    localparam logic signed [31:0] IMM21_MIN = -32'sd1048576;
    localparam logic signed [31:0] IMM21_MAX =  32'sd1048574;

    localparam logic [ADDR_W-1:0] ADDR_STEP  = ADDR_W'(4);
    localparam logic [ADDR_W-1:0] WORDS_FULL = ADDR_W'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_DONE
    } state_t;

    state_t state;

    logic signed [31:0] simm;
    logic               fits12;
    logic               fits13;
    logic               fits21;
    logic [31:0]        enc_word;
    logic               imm_ok;
    logic [ADDR_W-1:0]  words_inc;

    assign simm      = $signed(imm);
    assign words_inc = words + ADDR_W'(1);

    // Range tests shared by the formats. B and J targets are halfword
    // aligned, so their upper limits are the largest even value.
    assign fits12 = (simm >= IMM12_MIN) && (simm <= IMM12_MAX);
    assign fits13 = (simm >= IMM13_MIN) && (simm <= IMM13_MAX) && !imm[0];
    assign fits21 = (simm >= IMM21_MIN) && (simm <= IMM21_MAX) && !imm[0];

    // in_ready depends on state alone, so a producer may use it to decide
    // whether to raise in_valid without creating a combinational loop.
    assign in_ready = (state == ST_LOAD);

    // Encoder: packs the fields of the presented bundle into an RV32I word
    // and decides whether its immediate is representable in that format.
    // Fields that a format does not use are ignored. R has no immediate, so
    // it is always accepted.
    always_comb begin
        enc_word = 32'd0;
        imm_ok   = 1'b1;
        case (fmt)
            FMT_R: begin
                enc_word = {funct7, rs2, rs1, funct3, rd, OP_R};
            end
            FMT_I: begin
                enc_word = {imm[11:0], rs1, funct3, rd, OP_I};
                imm_ok   = fits12;
            end
            FMT_S: begin
                enc_word = {imm[11:5], rs2, rs1, funct3, imm[4:0], OP_S};
                imm_ok   = fits12;
            end
            FMT_B: begin
                enc_word = {imm[12], imm[10:5], rs2, rs1, funct3,
                            imm[4:1], imm[11], OP_B};
                imm_ok   = fits13;
            end
            FMT_J: begin
                enc_word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OP_J};
                imm_ok   = fits21;
            end
            FMT_U: begin
                enc_word = {imm[31:12], rd, OP_U};
                imm_ok   = (imm[11:0] == 12'd0);
            end
            FMT_LW: begin
                enc_word = {imm[11:0], rs1, funct3, rd, OP_LW};
                imm_ok   = fits12;
            end
            FMT_JALR: begin
                enc_word = {imm[11:0], rs1, funct3, rd, OP_JALR};
                imm_ok   = fits12;
            end
            default: begin
                enc_word = 32'd0;
                imm_ok   = 1'b0;
            end
        endcase
    end

    // Session controller and registered outputs.
    // mem_we and err are single-cycle pulses; they clear by default on every
    // edge and are set only by the edge that accepts a bundle.
    // mem_addr shows the address of the word being written while mem_we is
    // high and steps by 4 on the edge that follows each write. That keeps
    // back-to-back writes at consecutive addresses, and it keeps the address
    // still across rejected bundles.
    // words counts at the accept edge. As a result, the transition into DONE
    // and the done flag take effect from the cycle after the final accept.
    // A start pulse takes priority over any bundle presented with it. It
    // reopens the session from address 0 and leaves err_count alone.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= ST_IDLE;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= 32'd0;
            err       <= 1'b0;
            err_count <= 8'd0;
            words     <= '0;
            done      <= 1'b0;
        end else begin
            mem_we <= 1'b0;
            err    <= 1'b0;

            if (mem_we) begin
                mem_addr <= mem_addr + ADDR_STEP;
            end

            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state    <= ST_LOAD;
                        mem_addr <= '0;
                        words    <= '0;
                        done     <= 1'b0;
                    end
                end

                ST_LOAD: begin
                    if (start) begin
                        mem_addr <= '0;
                        words    <= '0;
                    end else if (in_valid) begin
                        if (imm_ok) begin
                            mem_we    <= 1'b1;
                            mem_wdata <= enc_word;
                            words     <= words_inc;
                            if (words_inc == WORDS_FULL) begin
                                state <= ST_DONE;
                                done  <= 1'b1;
                            end
                        end else begin
                            err <= 1'b1;
                            if (err_count != 8'hFF) begin
                                err_count <= err_count + 8'd1;
                            end
                        end
                    end
                end

                ST_DONE: begin
                    if (start) begin
                        state    <= ST_LOAD;
                        mem_addr <= '0;
                        words    <= '0;
                        done     <= 1'b0;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// ---------------------------------------------------------------------------
// tb_instr_encoder_loader
//
// Directed bench for instr_encoder_loader, built with DEPTH=4 so that a full
// session is short. Inputs change #1 after a rising edge. Outputs are sampled
// at that same point, after the edge has updated them.
// ---------------------------------------------------------------------------
module tb_instr_encoder_loader;

    localparam int ADDR_W = 10;
    localparam int DEPTH  = 4;

    logic              clk;
    logic              rst;
    logic              start;
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        fmt;
    logic [4:0]        rd;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [2:0]        funct3;
    logic [6:0]        funct7;
    logic [31:0]       imm;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              err;
    logic [7:0]        err_count;
    logic [ADDR_W-1:0] words;
    logic              done;

    int numChecks = 0;
    int passCount = 0;

    instr_encoder_loader #(
        .ADDR_W(ADDR_W),
        .DEPTH (DEPTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .fmt      (fmt),
        .rd       (rd),
        .rs1      (rs1),
        .rs2      (rs2),
        .funct3   (funct3),
        .funct7   (funct7),
        .imm      (imm),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .err      (err),
        .err_count(err_count),
        .words    (words),
        .done     (done)
    );

    // Free-running 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge, then settle past it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one field bundle onto the input bus
    task automatic applyStimulus(input logic v, input logic [2:0] f,
                                 input logic [4:0] d, input logic [4:0] s1,
                                 input logic [4:0] s2, input logic [2:0] f3,
                                 input logic [6:0] f7, input logic [31:0] im);
        in_valid = v;
        fmt      = f;
        rd       = d;
        rs1      = s1;
        rs2      = s2;
        funct3   = f3;
        funct7   = f7;
        imm      = im;
    endtask

    // One comparison: counts it, and reports a mismatch with $error
    task automatic checkOutput(input string tag, input logic [31:0] obs,
                               input logic [31:0] exp);
        numChecks++;
        assert (obs === exp) passCount++;
        else $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    initial begin
        rst   = 1'b0;
        start = 1'b0;
        applyStimulus(0, 3'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);

        // Reset state
        tick();
        tick();
        checkOutput("rst_in_ready",  32'(in_ready),  32'd0);
        checkOutput("rst_mem_we",    32'(mem_we),    32'd0);
        checkOutput("rst_done",      32'(done),      32'd0);
        checkOutput("rst_words",     32'(words),     32'd0);
        checkOutput("rst_err_count", 32'(err_count), 32'd0);
        checkOutput("rst_mem_addr",  32'(mem_addr),  32'd0);

        // Open a session; an R then an I bundle
        rst   = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        checkOutput("load_in_ready", 32'(in_ready), 32'd1);

        applyStimulus(1, 3'd0, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0);
        tick();
        checkOutput("r_we",    32'(mem_we),   32'd1);
        checkOutput("r_addr",  32'(mem_addr), 32'd0);
        checkOutput("r_wdata", mem_wdata,     32'h002081B3);
        checkOutput("r_words", 32'(words),    32'd1);

        applyStimulus(1, 3'd1, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
        tick();
        checkOutput("i_we",    32'(mem_we),   32'd1);
        checkOutput("i_addr",  32'(mem_addr), 32'd4);
        checkOutput("i_wdata", mem_wdata,     32'h00500093);

        in_valid = 1'b0;
        tick();
        checkOutput("idle_we", 32'(mem_we), 32'd0);

        // Reset mid-session while a bundle is presented
        applyStimulus(1, 3'd0, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0);
        rst = 1'b0;
        tick();
        checkOutput("midrst_in_ready", 32'(in_ready),  32'd0);
        checkOutput("midrst_we",       32'(mem_we),    32'd0);
        checkOutput("midrst_words",    32'(words),     32'd0);
        checkOutput("midrst_err_cnt",  32'(err_count), 32'd0);
        rst = 1'b1;
        tick();
        checkOutput("postrst_we",       32'(mem_we),   32'd0);
        checkOutput("postrst_in_ready", 32'(in_ready), 32'd0);
        in_valid = 1'b0;

        // Back-to-back S, B, J, U; the fourth write fills the DEPTH=4 session
        start = 1'b1;
        tick();
        start = 1'b0;
        applyStimulus(1, 3'd2, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8);
        tick();
        checkOutput("s_we",    32'(mem_we),   32'd1);
        checkOutput("s_addr",  32'(mem_addr), 32'd0);
        checkOutput("s_wdata", mem_wdata,     32'h0020A423);
        applyStimulus(1, 3'd3, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, -32'sd4);
        tick();
        checkOutput("b_we",    32'(mem_we),   32'd1);
        checkOutput("b_addr",  32'(mem_addr), 32'd4);
        checkOutput("b_wdata", mem_wdata,     32'hFE208EE3);
        applyStimulus(1, 3'd4, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd8);
        tick();
        checkOutput("j_we",    32'(mem_we),   32'd1);
        checkOutput("j_addr",  32'(mem_addr), 32'd8);
        checkOutput("j_wdata", mem_wdata,     32'h008000EF);
        applyStimulus(1, 3'd5, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000);
        tick();
        checkOutput("u_we",       32'(mem_we),   32'd1);
        checkOutput("u_addr",     32'(mem_addr), 32'd12);
        checkOutput("u_wdata",    mem_wdata,     32'h123452B7);
        checkOutput("u_done",     32'(done),     32'd1);
        checkOutput("u_in_ready", 32'(in_ready), 32'd0);
        in_valid = 1'b0;

        // Rejected bundles: no write, address and words hold
        start = 1'b1;
        tick();
        start = 1'b0;
        checkOutput("new_words", 32'(words),    32'd0);
        checkOutput("new_addr",  32'(mem_addr), 32'd0);
        applyStimulus(1, 3'd1, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048);
        tick();
        checkOutput("bad_i_err", 32'(err),    32'd1);
        checkOutput("bad_i_we",  32'(mem_we), 32'd0);
        applyStimulus(1, 3'd3, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd3);
        tick();
        checkOutput("bad_b_err", 32'(err),    32'd1);
        checkOutput("bad_b_we",  32'(mem_we), 32'd0);
        applyStimulus(1, 3'd5, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1);
        tick();
        checkOutput("bad_u_err",   32'(err),       32'd1);
        checkOutput("bad_u_we",    32'(mem_we),    32'd0);
        checkOutput("bad_err_cnt", 32'(err_count), 32'd3);
        checkOutput("bad_addr",    32'(mem_addr),  32'd0);
        checkOutput("bad_words",   32'(words),     32'd0);
        applyStimulus(1, 3'd1, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
        tick();
        checkOutput("after_bad_we",    32'(mem_we),   32'd1);
        checkOutput("after_bad_err",   32'(err),      32'd0);
        checkOutput("after_bad_addr",  32'(mem_addr), 32'd0);
        checkOutput("after_bad_wdata", mem_wdata,     32'h00500093);
        in_valid = 1'b0;

        // Fill a session with in_valid held high across 6 bundles
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 6; k++) begin
            applyStimulus(1, 3'd0, 5'(k + 1), 5'd1, 5'd2, 3'd0, 7'd0, 32'd0);
            tick();
            checkOutput($sformatf("fill_we_%0d", k), 32'(mem_we), (k < 4) ? 32'd1 : 32'd0);
            if (k < 4) begin
                checkOutput($sformatf("fill_addr_%0d", k), 32'(mem_addr), 32'(4 * k));
                checkOutput($sformatf("fill_wdata_%0d", k), mem_wdata,
                            32'h00208033 | (32'(k + 1) << 7));
            end
            if (k >= 3) begin
                checkOutput($sformatf("fill_done_%0d", k),  32'(done),     32'd1);
                checkOutput($sformatf("fill_ready_%0d", k), 32'(in_ready), 32'd0);
            end
        end
        checkOutput("fill_words", 32'(words), 32'd4);
        in_valid = 1'b0;

        start = 1'b1;
        tick();
        start = 1'b0;
        checkOutput("restart_ready", 32'(in_ready), 32'd1);
        checkOutput("restart_done",  32'(done),     32'd0);
        applyStimulus(1, 3'd0, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0);
        tick();
        checkOutput("restart_we",    32'(mem_we),   32'd1);
        checkOutput("restart_addr",  32'(mem_addr), 32'd0);
        checkOutput("restart_words", 32'(words),    32'd1);

        // 260 rejected bundles saturate err_count (already 3)
        applyStimulus(1, 3'd1, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048);
        for (int n = 0; n < 260; n++) begin
            tick();
        end
        checkOutput("sat_err_cnt", 32'(err_count), 32'd255);
        checkOutput("sat_words",   32'(words),     32'd1);

        // start with a valid bundle: bundle ignored, err_count kept
        applyStimulus(1, 3'd0, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0);
        start = 1'b1;
        tick();
        start = 1'b0;
        in_valid = 1'b0;
        checkOutput("start_we",      32'(mem_we),    32'd0);
        checkOutput("start_err",     32'(err),       32'd0);
        checkOutput("start_err_cnt", 32'(err_count), 32'd255);
        checkOutput("start_words",   32'(words),     32'd0);

        rst = 1'b0;
        tick();
        rst = 1'b1;
        checkOutput("final_rst_err_cnt", 32'(err_count), 32'd0);

        $display("%0d/%0d checks passed", passCount, numChecks);
        $finish;
    end

endmodule

// File: doc/instr_encoder_loader.md
Name: instr_encoder_loader

Overview:
- Instruction encoder and loader: the encode-side counterpart of the pipeline's opcode decoder.
- Accepts symbolic instruction fields over a valid/ready handshake and packs them into 32-bit RV32I words for the same opcode set the decoder recognises: R, I, S, B, J, U(LUI), LW, JALR.
- Writes each word sequentially into instruction memory.
- Used to bootstrap and self-load program memory before the core is released from stall.

Parameters:
- ADDR_W, 10, width of the byte address to instruction memory.
- DEPTH, 256, maximum number of words loaded per session.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-low reset.
- start  in  1  one-cycle pulse; opens a load session, clears the address and the word count.
- in_valid  in  1  field bundle valid.
- in_ready  out  1  block can accept a bundle this cycle.
- fmt  in  3  0=R, 1=I, 2=S, 3=B, 4=J, 5=U, 6=LW, 7=JALR.
- rd, rs1, rs2  in  5 each  register indices.
- funct3  in  3  funct3 field.
- funct7  in  7  funct7 field (R only).
- imm  in  32  signed immediate, unshifted byte value; for U this is the full 32-bit value.
- mem_we  out  1  instruction-memory write strobe.
- mem_addr  out  ADDR_W  byte address of the write.
- mem_wdata  out  32  encoded instruction.
- err  out  1  one-cycle pulse: the bundle was rejected.
- err_count  out  8  saturating count of rejected bundles.
- words  out  ADDR_W  words written in the current session.
- done  out  1  session full (words==DEPTH).

Behaviour:
- Reset (rst==0 at a clock edge):
  - State goes to IDLE.
  - in_ready, mem_we, err, done, mem_addr, mem_wdata, words and err_count all go to 0.
  - Reset mid-session aborts immediately; an in-flight write is not issued.
- State IDLE:
  - in_ready=0.
  - start -> LOAD; mem_addr and words go to 0, err_count is kept.
- State LOAD:
  - in_ready=1.
  - The accept edge is in_valid && in_ready.
  - Following that edge, the registered outputs are valid for exactly one cycle: mem_we=1 with mem_wdata and mem_addr, or err=1.
  - After a write: mem_addr += 4 and words += 1.
  - Accept-to-write latency is 1 cycle, throughput 1 bundle/cycle.
  - When words reaches DEPTH -> DONE.
- State DONE:
  - in_ready=0, done=1.
  - start -> LOAD (new session).
- start during LOAD restarts the session: address and words cleared, and any bundle presented in that same cycle is ignored.
- in_ready is combinational from state only; it never depends on in_valid.
- Encoding, with opcodes as used by the decoder:
  - R: funct7|rs2|rs1|funct3|rd|0110011
  - I, LW, JALR: imm[11:0]|rs1|funct3|rd|op, with op 0010011, 0000011, 1100111 respectively.
  - S: imm[11:5]|rs2|rs1|funct3|imm[4:0]|0100011
  - B: imm[12]|imm[10:5]|rs2|rs1|funct3|imm[4:1]|imm[11]|1100011
  - J: imm[20]|imm[10:1]|imm[11]|imm[19:12]|rd|1101111
  - U: imm[31:12]|rd|0110111
  - Fields that are unused for a format are ignored.
- Range checks; a violation means err pulse, no write, address and words unchanged:
  - I, S, LW, JALR: imm must be in -2048..2047.
  - B: imm must be in -4096..4094 and imm[0]==0.
  - J: imm must be in -2^20..2^20-2 and imm[0]==0.
  - U: imm[11:0] must be 0.
- err_count saturates at 255.
- A rejected bundle does not advance toward DONE.

Test Plan:
- Reset (rst=0) while in LOAD with in_valid=1 -> next cycle in_ready=0, mem_we=0, words=0, err_count=0, state IDLE; no write appears afterwards.
- start, then fmt=0 rd=3 rs1=1 rs2=2 funct3=0 funct7=0 -> one cycle later mem_we=1, mem_addr=0, mem_wdata=0x002081B3; then fmt=1 rd=1 rs1=0 imm=5 -> mem_addr=4, mem_wdata=0x00500093.
- Back-to-back bundles, one each cycle:
  - S rs2=2 rs1=1 funct3=2 imm=8 -> 0x0020A423.
  - B rs1=1 rs2=2 funct3=0 imm=-4 -> 0xFE208EE3.
  - J rd=1 imm=8 -> 0x008000EF.
  - U rd=5 imm=0x12345000 -> 0x123452B7.
  - Expect consecutive mem_we cycles at addresses 0, 4, 8, 12.
- Invalid bundles: I imm=2048, B imm=3, U imm=0x1 -> three err pulses, err_count=3, no mem_we, mem_addr unchanged; a valid bundle that follows is written at the unchanged address.
- DEPTH=4: stream 6 valid bundles with in_valid held high -> exactly 4 writes (addresses 0..12), done=1 and in_ready=0 from the cycle after the 4th accept; start pulse -> in_ready=1, next write at mem_addr=0, words=1.
- err_count saturation: 260 rejected bundles -> err_count=255; start has no effect on err_count, rst clears it to 0.
